// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-cycle stage of the 128-bit vector pipeline.
//
// Non-memory ops pass to the W register in one cycle. Loads and stores latch the
// M-side operands, raise a req/ack access to the data memory and stall execute
// until the memory acknowledges. If the memory never acknowledges, the access is
// abandoned after TIMEOUT wait cycles. The op then completes with zero read data
// and sets the sticky mem_err flag.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid_m .. write_data_m
//                       instruction presented by execute (held while stall_m=1)
//   stall_m             execute must hold its outputs (high in WAIT)
//   mem_req/we/addr/wdata, mem_ack/rdata
//                       variable-latency data-memory handshake
//   valid_w .. read_data_w
//                       W-side pipeline register feeding writeback
//   mem_err             sticky timeout flag
//   stall_cycles        saturating count of stalled cycles
module mem_access_stage #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT     = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_m,
    input  logic                   mem_read_m,
    input  logic                   mem_write_m,
    input  logic                   reg_write_m,
    input  logic [4:0]             rd_m,
    input  logic [1:0]             result_src_m,
    input  logic [DATA_W-1:0]      alu_result_m,
    input  logic [DATA_W-1:0]      write_data_m,
    output logic                   stall_m,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   valid_w,
    output logic                   reg_write_w,
    output logic [4:0]             rd_w,
    output logic [1:0]             result_src_w,
    output logic [DATA_W-1:0]      alu_result_w,
    output logic [DATA_W-1:0]      read_data_w,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             stateR;
    state_t             nextStateS;
    logic [CNT_W-1:0]   timeoutCntR;
    logic               regWriteR;
    logic [4:0]         rdR;
    logic [1:0]         resultSrcR;
    logic [DATA_W-1:0]  aluResultR;
    logic               startMemS;
    logic               startAluS;
    logic               timeoutS;
    logic               completeS;

    // Decode what happens at the coming edge; ack wins over a simultaneous timeout.
    always_comb begin
        startMemS = 1'b0;
        startAluS = 1'b0;
        timeoutS  = 1'b0;
        completeS = 1'b0;
        if (stateR == IDLE) begin
            startMemS = valid_m & (mem_read_m | mem_write_m);
            startAluS = valid_m & ~(mem_read_m | mem_write_m);
        end else begin
            timeoutS  = ~mem_ack & (timeoutCntR == TIMEOUT_LAST);
            completeS = mem_ack | timeoutS;
        end
    end

    // Next-state logic.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            IDLE:    nextStateS = startMemS ? WAIT : IDLE;
            WAIT:    nextStateS = completeS ? IDLE : WAIT;
            default: nextStateS = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    assign stall_m = (stateR == WAIT);

    // Memory port and latched M-side operands; held stable for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            regWriteR  <= 1'b0;
            rdR        <= 5'd0;
            resultSrcR <= 2'd0;
            aluResultR <= '0;
        end else if (startMemS) begin
            mem_req    <= 1'b1;
            mem_we     <= mem_write_m;  // read+write together is treated as a write
            mem_addr   <= alu_result_m[ADDR_W-1:0];
            mem_wdata  <= write_data_m;
            regWriteR  <= reg_write_m;
            rdR        <= rd_m;
            resultSrcR <= result_src_m;
            aluResultR <= alu_result_m;
        end else if (completeS) begin
            mem_req <= 1'b0;
        end
    end

    // Wait-cycle counter; runs only while an access is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeoutCntR <= '0;
        end else if ((stateR == WAIT) && !completeS) begin
            timeoutCntR <= timeoutCntR + CNT_W'(1);
        end else begin
            timeoutCntR <= '0;
        end
    end

    // W pipeline register: bubble unless an op completes at this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            rd_w         <= 5'd0;
            result_src_w <= 2'd0;
            alu_result_w <= '0;
            read_data_w  <= '0;
        end else if (startAluS) begin
            valid_w      <= 1'b1;
            reg_write_w  <= reg_write_m;
            rd_w         <= rd_m;
            result_src_w <= result_src_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= '0;
        end else if (completeS) begin
            valid_w      <= 1'b1;
            reg_write_w  <= regWriteR;
            rd_w         <= rdR;
            result_src_w <= resultSrcR;
            alu_result_w <= aluResultR;
            // Only an acknowledged read returns data; stores and timeouts give zero.
            read_data_w  <= (mem_ack && !mem_we) ? mem_rdata : '0;
        end else begin
            valid_w <= 1'b0;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (timeoutS) begin
            mem_err <= 1'b1;
        end else begin
            mem_err <= mem_err;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_m && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end else begin
            stall_cycles <= stall_cycles;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage. Ops are issued like an execute stage
// that holds its outputs while stalled; expected W results go to a queue when
// an op is accepted, and a monitor compares them whenever valid_w is seen.
module tb_mem_access_stage;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_m = 1'b0, mem_read_m = 1'b0, mem_write_m = 1'b0, reg_write_m = 1'b0;
    logic [4:0]    rd_m = 5'd0;
    logic [1:0]    result_src_m = 2'd0;
    logic [DW-1:0] alu_result_m = '0, write_data_m = '0;
    logic          stall_m, mem_req, mem_we, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;
    logic          valid_w, reg_write_w, mem_err;
    logic [4:0]    rd_w;
    logic [1:0]    result_src_w;
    logic [DW-1:0] alu_result_w, read_data_w;
    logic [SW-1:0] stall_cycles;

    mem_access_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst), .valid_m(valid_m), .mem_read_m(mem_read_m),
        .mem_write_m(mem_write_m), .reg_write_m(reg_write_m), .rd_m(rd_m),
        .result_src_m(result_src_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .stall_m(stall_m), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid_w(valid_w),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_src_w(result_src_w),
        .alu_result_w(alu_result_w), .read_data_w(read_data_w),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    rd;
        logic          rw;
        logic [1:0]    src;
        logic [DW-1:0] alu;
        logic [DW-1:0] rdat;
        logic          err;
        int            stall;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            lat;     // WAIT cycle in which ack is given; 0 = never
        logic [DW-1:0] rdata;
    } cfg_t;

    exp_t expQ[$];
    cfg_t cfgQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    logic errModel = 1'b0;
    int   stallModel = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Execute-stage model: present an op and hold it until the stage accepts it.
    task automatic issue(input logic rdOp, input logic wrOp, input logic rw, input logic [4:0] rd,
                         input logic [1:0] src, input logic [DW-1:0] alu,
                         input logic [DW-1:0] wdat, input int lat, input logic [DW-1:0] rdata);
        exp_t e;
        cfg_t c;
        int   g;
        logic isMem, timedOut;
        @(negedge clk);
        valid_m = 1'b1; mem_read_m = rdOp; mem_write_m = wrOp; reg_write_m = rw;
        rd_m = rd; result_src_m = src; alu_result_m = alu; write_data_m = wdat;
        g = 0;
        while (stall_m && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("issue_stall_bound", 1'b1, 1'b0);
        isMem    = rdOp | wrOp;
        timedOut = isMem && (lat == 0 || lat > TO);
        if (isMem) begin
            stallModel += timedOut ? TO : lat;
            c.addr = alu[AW-1:0]; c.we = wrOp; c.wdata = wdat; c.lat = lat; c.rdata = rdata;
            cfgQ.push_back(c);
        end
        if (timedOut) errModel = 1'b1;
        e.rd = rd; e.rw = rw; e.src = src; e.alu = alu;
        e.rdat  = (isMem && !wrOp && !timedOut) ? rdata : '0;
        e.err   = errModel;
        e.stall = stallModel;
        expQ.push_back(e);
        @(posedge clk);
        #1 valid_m = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (expQ.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("drain_bound", 1'b1, 1'b0);
    endtask

    // Monitor: every valid_w must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && valid_w) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL valid_w_unexpected: got 1 expected 0 (no op outstanding)");
                end else begin
                    e = expQ.pop_front();
                    check("rd_w", rd_w, e.rd);
                    check("reg_write_w", reg_write_w, e.rw);
                    check("result_src_w", result_src_w, e.src);
                    check("alu_result_w", alu_result_w, e.alu);
                    check("read_data_w", read_data_w, e.rdat);
                    check("mem_err", mem_err, e.err);
                    check("stall_cycles", stall_cycles, e.stall);
                end
            end
        end
    end

    // Memory responder: checks the request stays stable and acks in the chosen WAIT cycle.
    initial begin
        cfg_t c;
        int   k;
        forever begin
            @(negedge clk);
            if (!rst && mem_req) begin
                if (cfgQ.size() == 0) begin
                    check("mem_req_unexpected", mem_req, 1'b0);
                end else begin
                    c = cfgQ.pop_front();
                    k = 1;
                    while (mem_req && !rst && k < 200) begin
                        check("mem_addr", mem_addr, c.addr);
                        check("mem_we", mem_we, c.we);
                        check("mem_wdata", mem_wdata, c.wdata);
                        mem_ack   = (k == c.lat);
                        mem_rdata = (k == c.lat) ? c.rdata : rnd128();
                        @(negedge clk);
                        k++;
                    end
                    if (k >= 200) check("mem_req_drop_bound", 1'b1, 1'b0);
                    mem_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdOp, wrOp;
        logic vSeq [4];
        int   kind;

        // Reset state.
        #12;
        check("rst_stall_m", stall_m, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_valid_w", valid_w, 1'b0);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_stall_cycles", stall_cycles, '0);
        check("rst_alu_result_w", alu_result_w, '0);
        @(negedge clk);
        rst = 1'b0;

        // Single non-memory op.
        issue(1'b0, 1'b0, 1'b1, 5'd3, 2'd1, 128'hAAAA_0001, '0, 0, '0);
        check("alu_no_stall", stall_m, 1'b0);
        drain();

        // Load from 0x40, ack in the third WAIT cycle.
        issue(1'b1, 1'b0, 1'b1, 5'd7, 2'd0, 128'h40, '0, 3, 128'h1234);
        check("load_stall_m", stall_m, 1'b1);
        drain();
        check("load_stall_cycles", stall_cycles, 16'd3);

        // Store 0xDEAD to 0x80, ack in the first WAIT cycle.
        issue(1'b0, 1'b1, 1'b0, 5'd9, 2'd1, 128'h80, 128'hDEAD, 1, '0);
        drain();
        check("store_stall_cycles", stall_cycles, 16'd4);

        // Load that is never acknowledged, then an ALU op with mem_err still set.
        issue(1'b1, 1'b0, 1'b1, 5'd11, 2'd0, 128'h100, '0, 0, 128'h5555);
        issue(1'b0, 1'b0, 1'b1, 5'd12, 2'd1, 128'h77, '0, 0, '0);
        drain();
        check("timeout_mem_err", mem_err, 1'b1);
        check("timeout_mem_req", mem_req, 1'b0);

        // Reset in the second WAIT cycle of a load.
        issue(1'b1, 1'b0, 1'b1, 5'd13, 2'd0, 128'h200, '0, 0, '0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_mem_err", mem_err, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_stall_m", stall_m, 1'b0);
        check("midrst_valid_w", valid_w, 1'b0);
        expQ.delete();
        cfgQ.delete();
        errModel = 1'b0;
        stallModel = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ack_valid_w", valid_w, 1'b0);
            check("idle_ack_mem_req", mem_req, 1'b0);
        end
        mem_ack = 1'b0;
        check("post_rst_mem_err", mem_err, 1'b0);
        check("post_rst_stall_cycles", stall_cycles, '0);

        // Back-to-back ALU, load (ack in first WAIT cycle), ALU.
        @(posedge clk);
        #1;
        fork
            begin
                issue(1'b0, 1'b0, 1'b1, 5'd1, 2'd1, 128'h11, '0, 0, '0);
                issue(1'b1, 1'b0, 1'b1, 5'd2, 2'd0, 128'h300, '0, 1, 128'hBEEF);
                issue(1'b0, 1'b0, 1'b1, 5'd4, 2'd1, 128'h22, '0, 0, '0);
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    vSeq[i] = valid_w;
                end
            end
        join
        check("b2b_valid_0", vSeq[0], 1'b1);
        check("b2b_valid_1", vSeq[1], 1'b0);
        check("b2b_valid_2", vSeq[2], 1'b1);
        check("b2b_valid_3", vSeq[3], 1'b1);
        drain();

        // Randomized mix of ALU ops, loads, stores and timeouts.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            rdOp = (kind == 2) || (kind == 4);
            wrOp = (kind == 3) || (kind == 4);
            issue(rdOp, wrOp, 1'($urandom), 5'($urandom_range(0, 31)), 2'($urandom),
                  rnd128(), rnd128(), $urandom_range(0, 6), rnd128());
        end
        drain();
        check("final_stall_cycles", stall_cycles, stallModel[SW-1:0]);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
